// File: rtl/shiftreg_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | shiftreg_pkg : shared sizing helpers and bit-order encoding      |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
package shiftreg_pkg;

    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } bit_order_e;

    function automatic int unsigned calc_beats(input int unsigned width, input int unsigned lanes);
        return width / lanes;
    endfunction

    // A single-beat word still needs a 1-bit counter to keep ports legal.
    function automatic int unsigned cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shiftreg_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | shiftreg_fifo : show-ahead word FIFO with full-count level       |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
module shiftreg_fifo
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [WIDTH-1:0]                push_data,
    input  logic                            pop,
    output logic [WIDTH-1:0]                pop_data,
    output logic                            full,
    output logic                            empty,
    output logic [level_width(DEPTH)-1:0]   level
);

    localparam int unsigned c_AW = $clog2(DEPTH);
    localparam int unsigned c_LW = level_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;
    logic             w_do_pop;
    logic             w_do_push;

    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_level == c_LW'(DEPTH));
    assign empty    = (r_level == '0);
    assign level    = r_level;

endmodule
`default_nettype wire

// File: rtl/shiftreg_deser.sv
`default_nettype none
// +------------------------------------------------------------------+
// | shiftreg_deser : multi-lane serial-to-parallel deserialiser      |
// | Revision       : 1.0                                             |
// +------------------------------------------------------------------+
module shiftreg_deser
    import shiftreg_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 1,
    parameter int DEPTH     = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [LANES-1:0]                databit,
    input  logic                            sync,
    output logic [WIDTH-1:0]                dout,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic                            overflow,
    output logic                            frame_err,
    input  logic                            clr_err,
    output logic [level_width(DEPTH)-1:0]   level
);

    localparam int unsigned c_BEATS = calc_beats(WIDTH, LANES);
    localparam int unsigned c_CW    = cnt_width(c_BEATS);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_BEATS - 1);
    localparam bit_order_e c_ORDER  = (MSB_FIRST != 0) ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;

    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_next;
    logic [c_CW-1:0]  r_cnt;
    logic [c_CW-1:0]  w_idx;
    logic             w_last;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic             w_frame_set;
    logic             r_overflow;
    logic             r_frame_err;

    generate
        if (c_BEATS == 1) begin : g_single_beat
            assign w_shreg_next = databit;
        end else if (c_ORDER == ORDER_MSB_FIRST) begin : g_msb_first
            assign w_shreg_next = {r_shreg[WIDTH-LANES-1:0], databit};
        end else begin : g_lsb_first
            assign w_shreg_next = {databit, r_shreg[WIDTH-1:LANES]};
        end
    endgenerate

    // Sync forces this beat to index 0; the completed word is the next-state value.
    assign w_idx       = sync ? '0 : r_cnt;
    assign w_last      = en & (w_idx == c_LAST);
    assign w_pop       = ~w_empty & dout_ready;
    assign w_drop      = w_last & w_full & ~w_pop;
    assign w_frame_set = en & sync & (r_cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (en) begin
            r_shreg <= w_shreg_next;
            r_cnt   <= w_last ? '0 : (w_idx + c_CW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overflow  <= w_drop | (r_overflow & ~clr_err);
            r_frame_err <= w_frame_set | (r_frame_err & ~clr_err);
        end
    end

    shiftreg_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_last),
        .push_data (w_shreg_next),
        .pop       (dout_ready),
        .pop_data  (dout),
        .full      (w_full),
        .empty     (w_empty),
        .level     (level)
    );

    assign dout_valid = ~w_empty;
    assign overflow   = r_overflow;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire
